// File: rtl/div_chk_pkg.sv
// Shared types and default widths for the divided-clock checker.
package div_chk_pkg;

    typedef enum logic [1:0] {IDLE, SEEK, HIGH, LOW} chk_state_t;

    localparam int CNT_W_DEF = 8;
    localparam int ERR_W_DEF = 16;

endpackage

// File: rtl/div_edge_det.sv
// Edge detector for a divided clock sampled as data in the clk domain.
module div_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic div_in,
    output logic rise,
    output logic fall
);

    logic div_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            div_prev <= 1'b0;
        end else begin
            div_prev <= div_in;
        end
    end

    assign rise = div_in & ~div_prev;
    assign fall = ~div_in & div_prev;

endmodule

// File: rtl/div_clk_checker.sv
// Measures high/low run lengths of a divided clock, checks them against an
// expected half-period, and reports edges, lock status and errors.
module div_clk_checker
    import div_chk_pkg::*;
#(
    parameter int CNT_W        = CNT_W_DEF,
    parameter int LOCK_PERIODS = 4,
    parameter int ERR_W        = ERR_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             div_in,
    input  logic [CNT_W-1:0] exp_half,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] low_cnt,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int                GOOD_W   = $clog2(LOCK_PERIODS + 1);
    localparam logic [CNT_W-1:0]  RUN_MAX  = '1;
    localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_PERIODS);
    localparam logic [ERR_W-1:0]  ERR_MAX  = '1;

    chk_state_t        state, state_next;
    logic              rise, fall;
    logic [CNT_W-1:0]  run_cnt, run_next;
    logic [GOOD_W-1:0] good_cnt, good_next, good_inc;
    logic              high_ok, high_ok_next;
    logic [CNT_W-1:0]  high_next, low_next;
    logic              locked_next;
    logic              bad;
    logic              match;
    logic [ERR_W-1:0]  err_cnt_next;

    div_edge_det u_edge (
        .clk    (clk),
        .reset  (reset),
        .div_in (div_in),
        .rise   (rise),
        .fall   (fall)
    );

    // A zero expected half-period can never describe a real run.
    assign match        = (run_cnt == exp_half) && (exp_half != '0);
    assign good_inc     = (good_cnt == GOOD_MAX) ? good_cnt : good_cnt + GOOD_W'(1);
    assign err_cnt_next = (bad && (err_cnt != ERR_MAX)) ? err_cnt + ERR_W'(1) : err_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            run_cnt    <= '0;
            good_cnt   <= '0;
            high_ok    <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            high_cnt   <= '0;
            low_cnt    <= '0;
            locked     <= 1'b0;
            err        <= 1'b0;
            err_cnt    <= '0;
        end else begin
            state      <= state_next;
            run_cnt    <= run_next;
            good_cnt   <= good_next;
            high_ok    <= high_ok_next;
            rise_pulse <= rise;
            fall_pulse <= fall;
            high_cnt   <= high_next;
            low_cnt    <= low_next;
            locked     <= locked_next;
            err        <= bad;
            err_cnt    <= err_cnt_next;
        end
    end

    always_comb begin
        run_next = run_cnt;
        if (rise || fall) begin
            run_next = CNT_W'(1);
        end else if (run_cnt != RUN_MAX) begin
            run_next = run_cnt + CNT_W'(1);
        end
    end

    // Timeout takes priority over a compare, so a saturated run never matches.
    always_comb begin
        state_next   = state;
        good_next    = good_cnt;
        high_ok_next = high_ok;
        high_next    = high_cnt;
        low_next     = low_cnt;
        locked_next  = locked;
        bad          = 1'b0;

        if (!en) begin
            state_next   = IDLE;
            good_next    = '0;
            high_ok_next = 1'b0;
            locked_next  = 1'b0;
        end else begin
            case (state)
                IDLE: state_next = SEEK;
                SEEK: begin
                    if (rise) begin
                        state_next   = HIGH;
                        high_ok_next = 1'b0;
                    end
                end
                HIGH: begin
                    if (run_cnt == RUN_MAX) begin
                        bad        = 1'b1;
                        state_next = SEEK;
                    end else if (fall) begin
                        high_next    = run_cnt;
                        high_ok_next = match;
                        bad          = ~match;
                        state_next   = LOW;
                    end
                end
                LOW: begin
                    if (run_cnt == RUN_MAX) begin
                        bad        = 1'b1;
                        state_next = SEEK;
                    end else if (rise) begin
                        low_next   = run_cnt;
                        state_next = HIGH;
                        if (!match) begin
                            bad = 1'b1;
                        end else if (high_ok) begin
                            good_next = good_inc;
                            if (good_inc == GOOD_MAX) begin
                                locked_next = 1'b1;
                            end
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end

        if (bad) begin
            good_next    = '0;
            high_ok_next = 1'b0;
            locked_next  = 1'b0;
        end
    end

endmodule

// File: tb/tb_div_clk_checker.sv
// Scoreboard bench: expected edge/error events are queued by the stimulus and
// popped by a monitor whenever the checker reports a pulse.
module tb_div_clk_checker;

    typedef struct packed {
        logic        r;
        logic        f;
        logic        e;
        logic [7:0]  hc;
        logic [7:0]  lc;
        logic        lk;
        logic [15:0] ec;
    } ev_t;

    logic        clk;
    logic        reset;
    logic        en;
    logic        div_in;
    logic [7:0]  exp_half;
    logic        rise_pulse;
    logic        fall_pulse;
    logic [7:0]  high_cnt;
    logic [7:0]  low_cnt;
    logic        locked;
    logic        err;
    logic [15:0] err_cnt;

    ev_t exp_q[$];
    int  compared   = 0;
    int  mismatched = 0;

    div_clk_checker dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .div_in     (div_in),
        .exp_half   (exp_half),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .high_cnt   (high_cnt),
        .low_cnt    (low_cnt),
        .locked     (locked),
        .err        (err),
        .err_cnt    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_ev(input logic r, input logic f, input logic e,
                           input logic [7:0] hc, input logic [7:0] lc,
                           input logic lk, input logic [15:0] ec);
        ev_t ev;
        ev = '{r: r, f: f, e: e, hc: hc, lc: lc, lk: lk, ec: ec};
        exp_q.push_back(ev);
    endtask

    task automatic hold(input logic v, input int n);
        div_in = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Drops en, confirms lock is cleared, parks div_in low and re-enables.
    task automatic restart(input logic [7:0] hc, input logic [7:0] lc, input logic [15:0] ec);
        en = 1'b0;
        hold(div_in, 2);
        check("locked_after_en_drop", {31'd0, locked}, 32'd0);
        if (div_in) begin
            push_ev(0, 1, 0, hc, lc, 0, ec);
            hold(1'b0, 2);
        end
        en = 1'b1;
        hold(1'b0, 3);
    endtask

    // Monitor: every reported pulse must match the next queued expectation.
    initial begin
        ev_t act;
        ev_t req;
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && (rise_pulse === 1'b1 || fall_pulse === 1'b1 || err === 1'b1)) begin
                act = '{r: rise_pulse, f: fall_pulse, e: err, hc: high_cnt, lc: low_cnt,
                        lk: locked, ec: err_cnt};
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL unexpected_event @%0t: got r%b f%b e%b hc%0d lc%0d lk%b ec%0d, expected none",
                             $time, act.r, act.f, act.e, act.hc, act.lc, act.lk, act.ec);
                end else begin
                    req = exp_q.pop_front();
                    if (act !== req) begin
                        mismatched++;
                        $display("[TB] FAIL event @%0t: got r%b f%b e%b hc%0d lc%0d lk%b ec%0d, expected r%b f%b e%b hc%0d lc%0d lk%b ec%0d",
                                 $time, act.r, act.f, act.e, act.hc, act.lc, act.lk, act.ec,
                                 req.r, req.f, req.e, req.hc, req.lc, req.lk, req.ec);
                    end
                end
            end
        end
    end

    initial begin
        reset    = 1'b1;
        en       = 1'b0;
        div_in   = 1'b0;
        exp_half = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {rise_pulse, fall_pulse, high_cnt, low_cnt, locked, err, err_cnt},
              32'd0);
        reset = 1'b0;

        // div2 stream, half = 1
        exp_half = 8'd1;
        en       = 1'b1;
        hold(1'b0, 3);
        for (int k = 1; k <= 6; k++) begin
            push_ev(1, 0, 0, (k == 1) ? 8'd0 : 8'd1, (k == 1) ? 8'd0 : 8'd1, k > 4, 0);
            hold(1'b1, 1);
            push_ev(0, 1, 0, 8'd1, (k == 1) ? 8'd0 : 8'd1, k > 4, 0);
            hold(1'b0, 1);
        end

        // div6 stream, half = 3, then half changed to 2 mid high run
        exp_half = 8'd3;
        restart(8'd1, 8'd1, 16'd0);
        for (int k = 1; k <= 5; k++) begin
            push_ev(1, 0, 0, (k == 1) ? 8'd1 : 8'd3, (k == 1) ? 8'd1 : 8'd3, k > 4, 0);
            hold(1'b1, 3);
            push_ev(0, 1, 0, 8'd3, (k == 1) ? 8'd1 : 8'd3, k > 4, 0);
            hold(1'b0, 3);
        end
        push_ev(1, 0, 0, 8'd3, 8'd3, 1, 0);
        hold(1'b1, 1);
        exp_half = 8'd2;
        hold(1'b1, 2);
        push_ev(0, 1, 1, 8'd3, 8'd3, 0, 1);
        hold(1'b0, 3);

        // div4 stream with one stretched high run, then relock
        restart(8'd3, 8'd3, 16'd1);
        for (int k = 1; k <= 5; k++) begin
            push_ev(1, 0, 0, (k == 1) ? 8'd3 : 8'd2, (k == 1) ? 8'd3 : 8'd2, k > 4, 1);
            hold(1'b1, 2);
            push_ev(0, 1, 0, 8'd2, (k == 1) ? 8'd3 : 8'd2, k > 4, 1);
            hold(1'b0, 2);
        end
        push_ev(1, 0, 0, 8'd2, 8'd2, 1, 1);
        hold(1'b1, 3);
        push_ev(0, 1, 1, 8'd3, 8'd2, 0, 2);
        hold(1'b0, 2);
        push_ev(1, 0, 0, 8'd3, 8'd2, 0, 2);
        hold(1'b1, 2);
        for (int j = 1; j <= 4; j++) begin
            push_ev(0, 1, 0, 8'd2, 8'd2, 0, 2);
            hold(1'b0, 2);
            push_ev(1, 0, 0, 8'd2, 8'd2, j == 4, 2);
            hold(1'b1, 2);
        end

        // stuck low for 300 cycles: one timeout, then SEEK until the stream resumes
        push_ev(0, 1, 0, 8'd2, 8'd2, 1, 2);
        push_ev(0, 0, 1, 8'd2, 8'd2, 0, 3);
        hold(1'b0, 300);
        push_ev(1, 0, 0, 8'd2, 8'd2, 0, 3);
        hold(1'b1, 2);
        push_ev(0, 1, 0, 8'd2, 8'd2, 0, 3);
        hold(1'b0, 2);
        push_ev(1, 0, 0, 8'd2, 8'd2, 0, 3);
        hold(1'b1, 2);

        // upstream reset with en dropped mid-period, then clean relock
        en = 1'b0;
        hold(1'b1, 1);
        push_ev(0, 1, 0, 8'd2, 8'd2, 0, 3);
        hold(1'b0, 20);
        check("err_cnt_held_idle", {16'd0, err_cnt}, 32'd3);
        check("locked_idle", {31'd0, locked}, 32'd0);
        en = 1'b1;
        hold(1'b0, 5);
        for (int k = 1; k <= 5; k++) begin
            push_ev(1, 0, 0, 8'd2, 8'd2, k > 4, 3);
            hold(1'b1, 2);
            push_ev(0, 1, 0, 8'd2, 8'd2, k > 4, 3);
            hold(1'b0, 2);
        end

        // exp_half = 0 errors on both compares, then relock with err_cnt = 5
        exp_half = 8'd0;
        push_ev(1, 0, 1, 8'd2, 8'd2, 0, 4);
        hold(1'b1, 2);
        push_ev(0, 1, 1, 8'd2, 8'd2, 0, 5);
        hold(1'b0, 2);
        exp_half = 8'd2;
        push_ev(1, 0, 0, 8'd2, 8'd2, 0, 5);
        hold(1'b1, 2);
        for (int j = 1; j <= 4; j++) begin
            push_ev(0, 1, 0, 8'd2, 8'd2, 0, 5);
            hold(1'b0, 2);
            push_ev(1, 0, 0, 8'd2, 8'd2, j == 4, 5);
            hold(1'b1, 2);
        end
        check("locked_before_reset", {31'd0, locked}, 32'd1);
        check("err_cnt_before_reset", {16'd0, err_cnt}, 32'd5);

        reset  = 1'b1;
        en     = 1'b0;
        div_in = 1'b0;
        @(posedge clk);
        #1;
        check("reset_while_locked", {rise_pulse, fall_pulse, high_cnt, low_cnt, locked, err, err_cnt},
              32'd0);
        reset = 1'b0;
        hold(1'b0, 3);

        check("events_pending", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
